cam_capture: RTL and testbench

CAM_CAPTURE -- requirements
Module: cam_capture

---
 rtl/cam_capture.sv | 179 +++++++++++++++++
 tb/tb_cam_capture.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture.sv
// cam_capture: samples an 8-bit YUV422 camera bus into the clk domain and
// emits one luma byte per pixel, tagged with its column/row, as a one-cycle pulse.
module cam_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit Y_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic [7:0] value,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       is_val,
  output logic       frame_start
);

  typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, IN_LINE} state_t;

  localparam logic [10:0] H_LIM   = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic        LUMA_PH = Y_FIRST ? 1'b0 : 1'b1;
  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  // Two-stage synchronizer plus one history stage for edge detection
  logic       s1_pclk_q, s1_vsync_q, s1_href_q;
  logic [7:0] s1_data_q;
  logic       s2_pclk_q, s2_vsync_q, s2_href_q;
  logic [7:0] s2_data_q;
  logic       s3_pclk_q, s3_vsync_q, s3_href_q;

  state_t     state_q, state_d;
  logic [9:0] px_q, px_d;
  logic [9:0] line_q, line_d;
  logic       phase_q, phase_d;
  logic [7:0] value_q, value_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       is_val_q, is_val_d;
  logic       frame_start_q, frame_start_d;

  logic strobe, vsync_rise, vsync_fall, href_fall;
  logic take_byte, cur_phase;

  assign strobe     = s2_pclk_q & ~s3_pclk_q;
  assign vsync_rise = s2_vsync_q & ~s3_vsync_q;
  assign vsync_fall = ~s2_vsync_q & s3_vsync_q;
  assign href_fall  = ~s2_href_q & s3_href_q;

  // Move camera signals into the clk domain as one bundle so data stays aligned with its strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_pclk_q  <= 1'b0;
      s1_vsync_q <= 1'b0;
      s1_href_q  <= 1'b0;
      s1_data_q  <= 8'd0;
      s2_pclk_q  <= 1'b0;
      s2_vsync_q <= 1'b0;
      s2_href_q  <= 1'b0;
      s2_data_q  <= 8'd0;
      s3_pclk_q  <= 1'b0;
      s3_vsync_q <= 1'b0;
      s3_href_q  <= 1'b0;
    end else begin
      s1_pclk_q  <= cam_pclk;
      s1_vsync_q <= cam_vsync;
      s1_href_q  <= cam_href;
      s1_data_q  <= cam_data;
      s2_pclk_q  <= s1_pclk_q;
      s2_vsync_q <= s1_vsync_q;
      s2_href_q  <= s1_href_q;
      s2_data_q  <= s1_data_q;
      s3_pclk_q  <= s2_pclk_q;
      s3_vsync_q <= s2_vsync_q;
      s3_href_q  <= s2_href_q;
    end
  end

  // Next-state: frame/line tracking, then luma extraction for any accepted byte
  always_comb begin
    state_d       = state_q;
    px_d          = px_q;
    line_d        = line_q;
    phase_d       = phase_q;
    value_d       = value_q;
    x_d           = x_q;
    y_d           = y_q;
    is_val_d      = 1'b0;
    frame_start_d = 1'b0;
    take_byte     = 1'b0;
    cur_phase     = phase_q;

    if (vsync_rise) begin
      // A new vsync aborts whatever line was in progress, even if a byte arrives this cycle
      state_d = WAIT_FRAME;
      px_d    = 10'd0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_FRAME: begin
          if (vsync_fall) begin
            state_d       = WAIT_LINE;
            line_d        = 10'd0;
            px_d          = 10'd0;
            phase_d       = 1'b0;
            frame_start_d = 1'b1;
          end
        end
        WAIT_LINE: begin
          if (strobe && s2_href_q) begin
            state_d   = IN_LINE;
            take_byte = 1'b1;
            cur_phase = 1'b0;
          end
        end
        IN_LINE: begin
          if (href_fall) begin
            // Line done: an unpaired trailing byte is simply forgotten by resetting phase
            state_d = WAIT_LINE;
            px_d    = 10'd0;
            phase_d = 1'b0;
            if (line_q != CNT_MAX) line_d = line_q + 10'd1;
          end else if (strobe && s2_href_q) begin
            take_byte = 1'b1;
          end
        end
        default: state_d = WAIT_FRAME;
      endcase
    end

    if (take_byte) begin
      phase_d = ~cur_phase;
      if (cur_phase == LUMA_PH) begin
        if (({1'b0, px_q} < H_LIM) && ({1'b0, line_q} < V_LIM)) begin
          value_d  = s2_data_q;
          x_d      = px_q;
          y_d      = line_q;
          is_val_d = 1'b1;
        end
        if (px_q != CNT_MAX) px_d = px_q + 10'd1;
      end
    end
  end

  // Capture FSM state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_FRAME;
      px_q          <= 10'd0;
      line_q        <= 10'd0;
      phase_q       <= 1'b0;
      value_q       <= 8'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      is_val_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      px_q          <= px_d;
      line_q        <= line_d;
      phase_q       <= phase_d;
      value_q       <= value_d;
      x_q           <= x_d;
      y_q           <= y_d;
      is_val_q      <= is_val_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign value       = value_q;
  assign x           = x_q;
  assign y           = y_q;
  assign is_val      = is_val_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: drives a camera bus at clk/4 into three cam_capture
// configurations and checks every reported pixel against a scoreboard.
module tb_cam_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cam_pclk = 1'b0;
  logic       cam_vsync = 1'b1;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'd0;

  logic [7:0] value_a, value_b, value_c;
  logic [9:0] x_a, x_b, x_c, y_a, y_b, y_c;
  logic       is_val_a, is_val_b, is_val_c;
  logic       fs_out_a, fs_out_b, fs_out_c;

  always #5 clk = ~clk;

  // A: defaults (Y first); B: chroma first; C: tiny 2x1 active window
  cam_capture #(.H_ACTIVE(640), .V_ACTIVE(480), .Y_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .value(value_a), .x(x_a), .y(y_a),
    .is_val(is_val_a), .frame_start(fs_out_a));

  cam_capture #(.H_ACTIVE(640), .V_ACTIVE(480), .Y_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .value(value_b), .x(x_b), .y(y_b),
    .is_val(is_val_b), .frame_start(fs_out_b));

  cam_capture #(.H_ACTIVE(2), .V_ACTIVE(1), .Y_FIRST(1'b1)) dut_c (
    .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .value(value_c), .x(x_c), .y(y_c),
    .is_val(is_val_c), .frame_start(fs_out_c));

  typedef struct packed {
    logic [7:0] v;
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] ex;
    logic [9:0] ey;
    logic       luma_a;
    logic       luma_b;
  } vec_t;

  pix_t q_a[$];
  pix_t q_b[$];
  pix_t q_c[$];

  int n_tests = 0;
  int n_fail  = 0;
  int fs_a = 0, fs_b = 0, fs_c = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic cmp_pix(input string nm, input pix_t got, input pix_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%h x=%0d y=%0d required v=%h x=%0d y=%0d",
               nm, got.v, got.x, got.y, exp.v, exp.x, exp.y);
    end
  endtask

  // Scoreboard consumer: every is_val pulse must match the oldest expected pixel
  always @(negedge clk) begin
    if (is_val_a) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_pix_A: got v=%h x=%0d y=%0d required no pixel", value_a, x_a, y_a);
      end else cmp_pix("pix_A", pix_t'({value_a, x_a, y_a}), q_a.pop_front());
    end
    if (is_val_b) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_pix_B: got v=%h x=%0d y=%0d required no pixel", value_b, x_b, y_b);
      end else cmp_pix("pix_B", pix_t'({value_b, x_b, y_b}), q_b.pop_front());
    end
    if (is_val_c) begin
      if (q_c.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_pix_C: got v=%h x=%0d y=%0d required no pixel", value_c, x_c, y_c);
      end else cmp_pix("pix_C", pix_t'({value_c, x_c, y_c}), q_c.pop_front());
    end
    if (fs_out_a) fs_a++;
    if (fs_out_b) fs_b++;
    if (fs_out_c) fs_c++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One camera byte: data settles with pclk low for 2 clks, then pclk high for 2 clks
  task automatic send_byte(input logic [7:0] d, input bit vs_rise);
    cam_data = d;
    tick(2);
    cam_pclk = 1'b1;
    if (vs_rise) cam_vsync = 1'b1;
    tick(2);
    cam_pclk = 1'b0;
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    tick(4);
    cam_vsync = 1'b0;
    tick(4);
  endtask

  // Expected output for byte k of line ln, from the YUV422 ordering of each configuration
  task automatic push_exp(input logic [7:0] d, input int k, input int ln);
    if (k % 2 == 0) q_a.push_back({d, 10'(k / 2), 10'(ln)});
    else            q_b.push_back({d, 10'(k / 2), 10'(ln)});
    if ((k % 2 == 0) && (k / 2 < 2) && (ln < 1)) q_c.push_back({d, 10'(k / 2), 10'(ln)});
  endtask

  task automatic line_gen(input logic [7:0] base, input int nbytes, input int ln);
    cam_href = 1'b1;
    tick(2);
    for (int k = 0; k < nbytes; k++) begin
      push_exp(base + 8'(k), k, ln);
      send_byte(base + 8'(k), 1'b0);
    end
    tick(2);
    cam_href = 1'b0;
    tick(4);
  endtask

  task automatic check_drained(input string tag);
    tick(8);
    chk({"drain_A_", tag}, q_a.size(), 0);
    chk({"drain_B_", tag}, q_b.size(), 0);
    chk({"drain_C_", tag}, q_c.size(), 0);
    q_a.delete(); q_b.delete(); q_c.delete();
  endtask

  task automatic check_fs(input string tag, input int base, input int delta);
    chk({"frame_start_A_", tag}, fs_a - base, delta);
    chk({"frame_start_B_", tag}, fs_b - base, delta);
    chk({"frame_start_C_", tag}, fs_c - base, delta);
  endtask

  vec_t tbl[16];
  int   fs0;

  initial begin
    tbl[0]  = '{8'h10, 10'd0, 10'd0, 1'b1, 1'b0};
    tbl[1]  = '{8'h80, 10'd0, 10'd0, 1'b0, 1'b1};
    tbl[2]  = '{8'h20, 10'd1, 10'd0, 1'b1, 1'b0};
    tbl[3]  = '{8'h81, 10'd1, 10'd0, 1'b0, 1'b1};
    tbl[4]  = '{8'h30, 10'd2, 10'd0, 1'b1, 1'b0};
    tbl[5]  = '{8'h82, 10'd2, 10'd0, 1'b0, 1'b1};
    tbl[6]  = '{8'h40, 10'd3, 10'd0, 1'b1, 1'b0};
    tbl[7]  = '{8'h83, 10'd3, 10'd0, 1'b0, 1'b1};
    tbl[8]  = '{8'h11, 10'd0, 10'd1, 1'b1, 1'b0};
    tbl[9]  = '{8'h90, 10'd0, 10'd1, 1'b0, 1'b1};
    tbl[10] = '{8'h21, 10'd1, 10'd1, 1'b1, 1'b0};
    tbl[11] = '{8'h91, 10'd1, 10'd1, 1'b0, 1'b1};
    tbl[12] = '{8'h31, 10'd2, 10'd1, 1'b1, 1'b0};
    tbl[13] = '{8'h92, 10'd2, 10'd1, 1'b0, 1'b1};
    tbl[14] = '{8'h41, 10'd3, 10'd1, 1'b1, 1'b0};
    tbl[15] = '{8'h93, 10'd3, 10'd1, 1'b0, 1'b1};

    // Reset state
    tick(3);
    @(negedge clk);
    chk("rst_value_A", value_a, 0);
    chk("rst_x_A", x_a, 0);
    chk("rst_y_A", y_a, 0);
    chk("rst_is_val_A", is_val_a, 0);
    chk("rst_frame_start_A", fs_out_a, 0);
    tick(1);
    reset = 1'b0;
    tick(4);

    // 2 lines x 4 pixels from the vector table
    fs0 = fs_a;
    vsync_pulse();
    for (int ln = 0; ln < 2; ln++) begin
      cam_href = 1'b1;
      tick(2);
      for (int k = 0; k < 8; k++) begin
        vec_t r;
        r = tbl[ln * 8 + k];
        if (r.luma_a) q_a.push_back({r.data, r.ex, r.ey});
        if (r.luma_b) q_b.push_back({r.data, r.ex, r.ey});
        if (r.luma_a && r.ex < 10'd2 && r.ey < 10'd1) q_c.push_back({r.data, r.ex, r.ey});
        send_byte(r.data, 1'b0);
      end
      tick(2);
      cam_href = 1'b0;
      tick(4);
      // A byte strobed with href low must be ignored
      send_byte(8'hEE, 1'b0);
      tick(2);
    end
    check_drained("table");
    check_fs("table", fs0, 1);

    // Odd-length line: trailing byte discarded, next line restarts phase at 0
    fs0 = fs_a;
    vsync_pulse();
    line_gen(8'hA0, 5, 0);
    line_gen(8'hB0, 4, 1);
    check_drained("odd_line");
    check_fs("odd_line", fs0, 1);

    // vsync rises together with pixel 2's strobe: that pixel and the rest of the line are lost
    fs0 = fs_a;
    vsync_pulse();
    cam_href = 1'b1;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      push_exp(8'hC0 + 8'(k), k, 0);
      send_byte(8'hC0 + 8'(k), 1'b0);
    end
    send_byte(8'hC4, 1'b1);
    send_byte(8'hC5, 1'b0);
    tick(2);
    cam_href = 1'b0;
    tick(4);
    cam_vsync = 1'b0;
    tick(4);
    line_gen(8'hD0, 4, 0);
    check_drained("vsync_abort");
    check_fs("vsync_abort", fs0, 2);

    // Reset in the middle of line 1
    fs0 = fs_a;
    vsync_pulse();
    line_gen(8'hE0, 4, 0);
    cam_href = 1'b1;
    tick(2);
    for (int k = 0; k < 4; k++) begin
      push_exp(8'hE8 + 8'(k), k, 1);
      send_byte(8'hE8 + 8'(k), 1'b0);
    end
    tick(3);
    chk("pre_rst_y_A", y_a, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_value_A", value_a, 0);
    chk("mid_rst_x_A", x_a, 0);
    chk("mid_rst_y_A", y_a, 0);
    chk("mid_rst_value_B", value_b, 0);
    chk("mid_rst_value_C", value_c, 0);
    chk("mid_rst_x_C", x_c, 0);
    chk("mid_rst_is_val", {is_val_a, is_val_b, is_val_c}, 0);
    tick(1);
    send_byte(8'hEC, 1'b0);
    send_byte(8'hED, 1'b0);
    tick(2);
    cam_href = 1'b0;
    tick(4);
    cam_href = 1'b1;
    tick(2);
    for (int k = 0; k < 4; k++) send_byte(8'h70 + 8'(k), 1'b0);
    tick(2);
    cam_href = 1'b0;
    tick(4);
    vsync_pulse();
    line_gen(8'hF0, 2, 0);
    check_drained("reset_mid_line");
    check_fs("reset_mid_line", fs0, 2);

    // Single pclk pulse: exact strobe-to-is_val latency
    fs0 = fs_a;
    vsync_pulse();
    cam_href = 1'b1;
    tick(2);
    cam_data = 8'h5A;
    tick(1);
    cam_pclk = 1'b1;
    q_a.push_back({8'h5A, 10'd0, 10'd0});
    q_c.push_back({8'h5A, 10'd0, 10'd0});
    @(posedge clk);
    @(posedge clk);
    #1;
    cam_pclk = 1'b0;
    @(negedge clk);
    chk("lat_early_A", is_val_a, 0);
    @(negedge clk);
    chk("lat_on_A", is_val_a, 1);
    chk("lat_on_C", is_val_c, 1);
    chk("lat_on_value_A", value_a, 8'h5A);
    @(negedge clk);
    chk("lat_pulse_width_A", is_val_a, 0);
    tick(4);
    cam_href = 1'b0;
    check_drained("latency");
    check_fs("latency", fs0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
